// File: rtl/toeplitz_src.sv
// ---------------------------------------------------------------------------
// toeplitz_src
//
// Coefficient-store responder for the toeplitz_mat read port. It answers
// each rd/addr request with one element of an NxN Toeplitz matrix. The
// matrix is stored only as its generator diagonals, which the system loader
// writes serially beforehand.
//
// Build option (macro TOEPLITZ_SYM_EN):
//   defined   : symmetric Toeplitz, NC = N coefficients, idx = |row-col|
//   undefined : general Toeplitz,   NC = 2N-1,           idx = row-col+(N-1)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   load       in   1   pulse: start or restart a coefficient load
//   wr_en      in   1   coefficient write strobe, honoured in LOAD only
//   wr_data    in   DW  coefficient word
//   load_done  out  1   one-cycle pulse after the last coefficient is written
//   busy       out  1   high while in LOAD
//   rd         in   1   read request
//   addr       in   AW  {row, col} of the requested element
//   data       out  DW  element value
//   data_vld   out  1   one-cycle pulse, data valid
//   err        out  1   one-cycle pulse, the read was served outside READY
// ---------------------------------------------------------------------------
module toeplitz_src #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int N  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          load_done,
    output logic          busy,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          data_vld,
    output logic          err
);

    localparam int H = AW / 2;

`ifdef TOEPLITZ_SYM_EN
    localparam int NC = N;
`else
    localparam int NC = 2 * N - 1;
`endif

    localparam int IW = $clog2(NC);       // coefficient index width
    localparam int CW = $clog2(NC + 1);   // load counter must reach NC

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic            busy_reg;
    logic            load_done_reg;
    logic [DW-1:0]   data_reg;
    logic            data_vld_reg;
    logic            err_reg;
    logic [DW-1:0]   coef_reg [NC];

    logic [H-1:0]    row;
    logic [H-1:0]    col;
    logic [IW-1:0]   rd_idx;

    assign row = addr[AW-1:H];
    assign col = addr[H-1:0];

`ifdef TOEPLITZ_SYM_EN
    // Diagonals +k and -k share coefficient k.
    logic [H-1:0] diff;
    assign diff   = (row >= col) ? (row - col) : (col - row);
    assign rd_idx = IW'(diff);
`else
    // One extra bit keeps row-col+(N-1) in 0..2N-2 without wrap.
    localparam logic [H:0] DIAG_OFS = (H + 1)'(N - 1);
    logic [H:0] idx_wide;
    assign idx_wide = {1'b0, row} + DIAG_OFS - {1'b0, col};
    assign rd_idx   = IW'(idx_wide);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            load_done_reg <= 1'b0;
            data_reg      <= '0;
            data_vld_reg  <= 1'b0;
            err_reg       <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            load_done_reg <= 1'b0;
            data_vld_reg  <= rd;
            err_reg       <= 1'b0;

            // Read path uses the state before any load in this cycle takes
            // effect, so a load+rd in READY is served from the old table.
            // Outside READY the table may be a mix of old and new values,
            // so a flagged zero is returned instead.
            if (rd) begin
                if (state_reg == READY) begin
                    data_reg <= coef_reg[rd_idx];
                end else begin
                    data_reg <= '0;
                    err_reg  <= 1'b1;
                end
            end

            case (state_reg)
                IDLE, READY: begin
                    if (load) begin
                        state_reg <= LOAD;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    // load has priority over a simultaneous write.
                    if (load) begin
                        count_reg <= '0;
                    end else if (wr_en) begin
                        coef_reg[count_reg[IW-1:0]] <= wr_data;
                        if (count_reg == CW'(NC - 1)) begin
                            state_reg     <= READY;
                            busy_reg      <= 1'b0;
                            load_done_reg <= 1'b1;
                            count_reg     <= CW'(NC);
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign load_done = load_done_reg;
    assign busy      = busy_reg;
    assign data      = data_reg;
    assign data_vld  = data_vld_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_toeplitz_src.sv
module tb_toeplitz_src;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int N  = 16;
`ifdef TOEPLITZ_SYM_EN
    localparam int NC = N;
`else
    localparam int NC = 2 * N - 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          load_done;
    logic          busy;
    logic          rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data;
    logic          data_vld;
    logic          err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic [AW-1:0] a;
    } exp_t;

    exp_t sb[$];
    logic rd_sampled = 1'b0;
    logic [DW-1:0] mc [NC];

    toeplitz_src #(.DW(DW), .AW(AW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .load_done (load_done),
        .busy      (busy),
        .rd        (rd),
        .addr      (addr),
        .data      (data),
        .data_vld  (data_vld),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Remember whether a read was accepted at this rising edge.
    always @(posedge clk) rd_sampled = rd && rst_n;

    // Scoreboard: every accepted read must produce exactly one response
    // on the following cycle, and nothing else may produce data_vld.
    always @(negedge clk) begin
        if (rd_sampled || data_vld) begin
            checks++;
            if (data_vld !== rd_sampled) begin
                failures++;
                $display("FAIL data_vld got=%b exp=%b", data_vld, rd_sampled);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_empty got=response exp=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (data !== e.d || err !== e.e) begin
                    failures++;
                    $display("FAIL read addr=%02h got data=%04h err=%b exp data=%04h err=%b",
                             e.a, data, err, e.d, e.e);
                end else begin
                    $display("read addr=%02h data=%04h err=%b ok", e.a, data, err);
                end
            end
        end
    end

    function automatic logic [DW-1:0] model_elem(input logic [AW-1:0] a);
        int r, c, d;
        r = int'(a[AW-1:AW/2]);
        c = int'(a[AW/2-1:0]);
        d = r - c;
`ifdef TOEPLITZ_SYM_EN
        if (d < 0) d = -d;
        return mc[d];
`else
        return mc[d + N - 1];
`endif
    endfunction

    // Drive one read for the next edge and queue its expectation.
    // The caller releases rd when the burst is over.
    task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.d = d; x.e = e; x.a = a;
        sb.push_back(x);
        rd = 1'b1;
        addr = a;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        rd = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        for (int i = 0; i < NC; i++) mc[i] = '0;
        #1;
        checks++;
        if ({data, data_vld, err, load_done, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset got data=%04h vld=%b err=%b done=%b busy=%b exp all 0",
                     data, data_vld, err, load_done, busy);
        end else begin
            $display("reset outputs cleared ok");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse load, then nwr consecutive writes of base (+k if inc).
    task automatic do_load(input logic [DW-1:0] base, input int nwr, input bit inc);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_load got=%b exp=1", busy);
        end
        for (int k = 0; k < nwr; k++) begin
            wr_en = 1'b1;
            wr_data = inc ? base + DW'(k) : base;
            if (k < NC) mc[k] = wr_data;
            @(negedge clk);
            checks++;
            if (load_done !== (k == NC - 1) || busy !== (k != NC - 1)) begin
                failures++;
                $display("FAIL load_write k=%0d got done=%b busy=%b exp done=%b busy=%b",
                         k, load_done, busy, (k == NC - 1), (k != NC - 1));
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0 || busy !== (nwr < NC)) begin
            failures++;
            $display("FAIL load_end got done=%b busy=%b exp done=0 busy=%b",
                     load_done, busy, (nwr < NC));
        end else begin
            $display("load base=%04h writes=%0d ok", base, nwr);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        for (int i = 0; i < NC; i++) mc[i] = '0;
        #1;
        checks++;
        if ({data, data_vld, err, load_done, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got data=%04h vld=%b err=%b done=%b busy=%b exp all 0",
                     data, data_vld, err, load_done, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_rd(8'h00, 16'h0000, 1'b1);
        idle_cycles(2);
    endtask

`ifndef TOEPLITZ_SYM_EN
    task automatic test_load_ramp();
        do_load(16'h0100, NC, 1'b1);
        issue_rd(8'h00, 16'h010F, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        issue_rd(8'hF0, 16'h011E, 1'b0);
        issue_rd(8'h0F, 16'h0100, 1'b0);
        issue_rd(8'h37, 16'h010B, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 255));
            issue_rd(a, model_elem(a), 1'b0);
        end
        idle_cycles(2);
    endtask

    task automatic test_reload_collision();
        load = 1'b1;
        issue_rd(8'h11, 16'h010F, 1'b0);
        load = 1'b0;
        rd = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL collision_busy got=%b exp=1", busy);
        end
        issue_rd(8'h22, 16'h0000, 1'b1);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_load();
        do_load(16'h5a5a, 10, 1'b1);
        apply_reset();
        do_load(16'hccbb, NC, 1'b0);
        issue_rd(8'h00, 16'hccbb, 1'b0);
        issue_rd(8'hF0, 16'hccbb, 1'b0);
        issue_rd(8'h0F, 16'hccbb, 1'b0);
        issue_rd(8'h9C, 16'hccbb, 1'b0);
        idle_cycles(2);
        // data now holds a non-zero value; reset must clear it at once.
        apply_reset();
        issue_rd(8'h44, 16'h0000, 1'b1);
        idle_cycles(2);
    endtask
`else
    task automatic test_sym();
        do_load(16'h2200, NC, 1'b1);
        // A write after completion must not land anywhere.
        wr_en = 1'b1;
        wr_data = 16'hFFFF;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (load_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sym_extra_write got done=%b busy=%b exp 0 0", load_done, busy);
        end
        issue_rd(8'h52, 16'h2203, 1'b0);
        issue_rd(8'h25, 16'h2203, 1'b0);
        issue_rd(8'h00, 16'h2200, 1'b0);
        issue_rd(8'hF0, 16'h220F, 1'b0);
        issue_rd(8'h0F, 16'h220F, 1'b0);
        idle_cycles(2);
    endtask
`endif

    initial begin
        test_reset();
`ifndef TOEPLITZ_SYM_EN
        test_load_ramp();
        test_back_to_back();
        test_reload_collision();
        test_reset_mid_load();
`else
        test_sym();
`endif
        idle_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
